// File: rtl/program_loader.sv
// Streams instruction words into instruction memory, then holds the core in
// reset for a programmable number of cycles before releasing it to run.
module program_loader #(
  parameter int unsigned ADDR_W      = 20,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned MEM_DEPTH   = 2**20,
  parameter int unsigned HOLD_CYCLES = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] baseAddr,
  input  logic [ADDR_W-1:0] wordCount,
  input  logic [DATA_W-1:0] inData,
  input  logic              inValid,
  output logic              inReady,
  output logic [ADDR_W-1:0] instrWriteAddress,
  output logic [DATA_W-1:0] instrWriteData,
  output logic              instrWriteEnable,
  output logic              coreReset,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StLoad = 2'd1;
  localparam logic [1:0] StHold = 2'd2;
  localparam logic [1:0] StRun  = 2'd3;

  localparam logic [ADDR_W-1:0] AddrOne  = ADDR_W'(1);
  localparam logic [7:0]        HoldLast = 8'(HOLD_CYCLES - 1);

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] count_q, count_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [7:0]        hold_q, hold_d;
  logic              in_ready_q, in_ready_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              we_q, we_d;
  logic              core_reset_q, core_reset_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic              hs;
  logic [ADDR_W-1:0] addr;
  logic              in_range;

  // Next-state logic; every output is a flop fed from the next state so
  // nothing combinational reaches a port.
  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    count_d  = count_q;
    idx_d    = idx_q;
    hold_d   = hold_q;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    we_d     = 1'b0;
    err_d    = err_q;
    hs       = in_ready_q && inValid;
    addr     = base_q + idx_q;  // wraps mod 2**ADDR_W
    in_range = 64'(addr) < 64'(MEM_DEPTH);

    case (state_q)
      StIdle, StRun: begin
        if (start) begin
          if (wordCount != '0) begin
            base_d  = baseAddr;
            count_d = wordCount;
            idx_d   = '0;
            err_d   = 1'b0;
            state_d = StLoad;
          end else begin
            hold_d  = '0;
            state_d = StHold;
          end
        end
      end
      StLoad: begin
        if (hs) begin
          waddr_d = addr;
          wdata_d = inData;
          // Out-of-range words are consumed but never written.
          if (in_range) we_d = 1'b1;
          else          err_d = 1'b1;
          idx_d = idx_q + AddrOne;
          if (idx_q == count_q - AddrOne) begin
            hold_d  = '0;
            state_d = StHold;
          end
        end
      end
      StHold: begin
        if (hold_q == HoldLast) state_d = StRun;
        else                    hold_d  = hold_q + 8'd1;
      end
      default: state_d = StIdle;
    endcase

    in_ready_d   = (state_d == StLoad);
    busy_d       = (state_d == StLoad) || (state_d == StHold);
    done_d       = (state_d == StRun);
    core_reset_d = (state_d != StRun);
  end

  // State and registered outputs; synchronous reset wins over everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      base_q       <= '0;
      count_q      <= '0;
      idx_q        <= '0;
      hold_q       <= '0;
      in_ready_q   <= 1'b0;
      waddr_q      <= '0;
      wdata_q      <= '0;
      we_q         <= 1'b0;
      core_reset_q <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      base_q       <= base_d;
      count_q      <= count_d;
      idx_q        <= idx_d;
      hold_q       <= hold_d;
      in_ready_q   <= in_ready_d;
      waddr_q      <= waddr_d;
      wdata_q      <= wdata_d;
      we_q         <= we_d;
      core_reset_q <= core_reset_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  assign inReady           = in_ready_q;
  assign instrWriteAddress = waddr_q;
  assign instrWriteData    = wdata_q;
  assign instrWriteEnable  = we_q;
  assign coreReset         = core_reset_q;
  assign busy              = busy_q;
  assign done              = done_q;
  assign err               = err_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: basic load, stall, range error,
// start-during-load, zero-count reload and reset mid-load.
module tb_program_loader;

  localparam int unsigned AW = 20;
  localparam int unsigned DW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] baseAddr;
  logic [AW-1:0] wordCount;
  logic [DW-1:0] inData;
  logic          inValid;
  logic          inReady;
  logic [AW-1:0] instrWriteAddress;
  logic [DW-1:0] instrWriteData;
  logic          instrWriteEnable;
  logic          coreReset;
  logic          busy;
  logic          done;
  logic          err;

  int total = 0;
  int bad   = 0;
  int wr_cnt = 0;
  int wr_mark;

  logic [15:0] words [4];

  program_loader #(
    .ADDR_W     (AW),
    .DATA_W     (DW),
    .MEM_DEPTH  (64),
    .HOLD_CYCLES(4)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .baseAddr         (baseAddr),
    .wordCount        (wordCount),
    .inData           (inData),
    .inValid          (inValid),
    .inReady          (inReady),
    .instrWriteAddress(instrWriteAddress),
    .instrWriteData   (instrWriteData),
    .instrWriteEnable (instrWriteEnable),
    .coreReset        (coreReset),
    .busy             (busy),
    .done             (done),
    .err              (err)
  );

  always #5 clk = ~clk;

  // Count write strobes, sampled mid-cycle.
  always @(negedge clk) if (instrWriteEnable === 1'b1) wr_cnt++;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (done !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    chk(tag, 32'(done), 32'd1);
  endtask

  initial begin
    words[0] = 16'h5800;
    words[1] = 16'h0000;
    words[2] = 16'h5900;
    words[3] = 16'h0002;

    reset = 1'b1; start = 1'b0; baseAddr = '0; wordCount = '0;
    inData = '0; inValid = 1'b0;
    step(); step();
    chk("rst_coreReset", 32'(coreReset), 32'd1);
    chk("rst_inReady", 32'(inReady), 32'd0);
    chk("rst_we", 32'(instrWriteEnable), 32'd0);
    chk("rst_addr", 32'(instrWriteAddress), 32'd0);
    chk("rst_data", 32'(instrWriteData), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);

    // Reset beats a simultaneous start.
    start = 1'b1; wordCount = 20'd4; baseAddr = 20'd32;
    step();
    chk("rst_prio_busy", 32'(busy), 32'd0);
    chk("rst_prio_ready", 32'(inReady), 32'd0);
    reset = 1'b0; start = 1'b0;
    step();

    // Basic load: 4 words at 32..35.
    wr_mark = wr_cnt;
    start = 1'b1; baseAddr = 20'd32; wordCount = 20'd4;
    step();
    start = 1'b0;
    chk("load_ready", 32'(inReady), 32'd1);
    chk("load_busy", 32'(busy), 32'd1);
    chk("load_we0", 32'(instrWriteEnable), 32'd0);
    for (int i = 0; i < 4; i++) begin
      inValid = 1'b1; inData = words[i];
      step();
      chk("basic_we", 32'(instrWriteEnable), 32'd1);
      chk("basic_addr", 32'(instrWriteAddress), 32'(32 + i));
      chk("basic_data", 32'(instrWriteData), 32'(words[i]));
    end
    inValid = 1'b0;
    chk("basic_last_ready", 32'(inReady), 32'd0);
    chk("basic_hold_busy", 32'(busy), 32'd1);
    step();
    chk("basic_hold_we", 32'(instrWriteEnable), 32'd0);
    chk("basic_hold_cr1", 32'(coreReset), 32'd1);
    step(); step();
    chk("basic_hold_cr4", 32'(coreReset), 32'd1);
    chk("basic_hold_done", 32'(done), 32'd0);
    step();
    chk("basic_run_cr", 32'(coreReset), 32'd0);
    chk("basic_run_done", 32'(done), 32'd1);
    chk("basic_run_err", 32'(err), 32'd0);
    chk("basic_run_busy", 32'(busy), 32'd0);
    chk("basic_wr_count", 32'(wr_cnt - wr_mark), 32'd4);

    // Stall, plus a start pulse during LOAD that must be ignored.
    wr_mark = wr_cnt;
    start = 1'b1; baseAddr = 20'd10; wordCount = 20'd3;
    step();
    start = 1'b0;
    chk("reload_cr", 32'(coreReset), 32'd1);
    chk("reload_done", 32'(done), 32'd0);
    inValid = 1'b1; inData = 16'h1111;
    step();
    chk("stall_addr0", 32'(instrWriteAddress), 32'd10);
    chk("stall_data0", 32'(instrWriteData), 32'h1111);
    inData = 16'h2222;
    step();
    chk("stall_addr1", 32'(instrWriteAddress), 32'd11);
    chk("stall_data1", 32'(instrWriteData), 32'h2222);
    inValid = 1'b0; inData = 16'hdead;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin start = 1'b1; wordCount = '0; baseAddr = '0; end
      step();
      start = 1'b0;
      chk("stall_we", 32'(instrWriteEnable), 32'd0);
      chk("stall_ready", 32'(inReady), 32'd1);
    end
    inValid = 1'b1; inData = 16'h3333;
    step();
    inValid = 1'b0;
    chk("stall_we2", 32'(instrWriteEnable), 32'd1);
    chk("stall_addr2", 32'(instrWriteAddress), 32'd12);
    chk("stall_data2", 32'(instrWriteData), 32'h3333);
    chk("stall_ready_off", 32'(inReady), 32'd0);
    wait_done("stall_run");
    chk("stall_wr_count", 32'(wr_cnt - wr_mark), 32'd3);

    // Range error with MEM_DEPTH=64.
    wr_mark = wr_cnt;
    start = 1'b1; baseAddr = 20'd62; wordCount = 20'd4;
    step();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      inValid = 1'b1; inData = 16'(16'h00a0 + i);
      step();
      chk("range_we", 32'(instrWriteEnable), (i < 2) ? 32'd1 : 32'd0);
      if (i < 2) chk("range_addr", 32'(instrWriteAddress), 32'(62 + i));
      chk("range_err", 32'(err), (i < 2) ? 32'd0 : 32'd1);
    end
    inValid = 1'b0;
    wait_done("range_run");
    chk("range_err_sticky", 32'(err), 32'd1);
    chk("range_wr_count", 32'(wr_cnt - wr_mark), 32'd2);

    // Zero-count reload from RUN.
    wr_mark = wr_cnt;
    start = 1'b1; wordCount = '0;
    step();
    start = 1'b0;
    chk("zero_cr", 32'(coreReset), 32'd1);
    chk("zero_done", 32'(done), 32'd0);
    chk("zero_busy", 32'(busy), 32'd1);
    chk("zero_ready", 32'(inReady), 32'd0);
    step(); step(); step();
    chk("zero_cr4", 32'(coreReset), 32'd1);
    step();
    chk("zero_run_cr", 32'(coreReset), 32'd0);
    chk("zero_run_done", 32'(done), 32'd1);
    chk("zero_wr_count", 32'(wr_cnt - wr_mark), 32'd0);

    // Reset after the second handshake.
    wr_mark = wr_cnt;
    start = 1'b1; baseAddr = 20'd5; wordCount = 20'd5;
    step();
    start = 1'b0;
    inValid = 1'b1; inData = 16'h0101;
    step();
    chk("mid_addr0", 32'(instrWriteAddress), 32'd5);
    inData = 16'h0202;
    step();
    chk("mid_addr1", 32'(instrWriteAddress), 32'd6);
    inData = 16'h0303; reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mid_rst_we", 32'(instrWriteEnable), 32'd0);
    chk("mid_rst_addr", 32'(instrWriteAddress), 32'd0);
    chk("mid_rst_data", 32'(instrWriteData), 32'd0);
    chk("mid_rst_cr", 32'(coreReset), 32'd1);
    chk("mid_rst_ready", 32'(inReady), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_err", 32'(err), 32'd0);
    step(); step(); step();
    chk("mid_idle_ready", 32'(inReady), 32'd0);
    chk("mid_idle_we", 32'(instrWriteEnable), 32'd0);
    inValid = 1'b0;
    step();
    chk("mid_wr_count", 32'(wr_cnt - wr_mark), 32'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
